serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract sequencer built around a single full_adder cell. It shifts WIDTH-bit operands through that one cell, one bit per clock, LSB first, with a registered carry between cycles. Operands enter and results leave over valid/ready handshakes. This is the area-minimal arithmetic option, used where a WIDTH-bit ripple adder is too large.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
data_A  input  WIDTH  operand A
data_B  input  WIDTH  operand B
carry_in  input  1  carry into bit 0 (add mode only)
sub  input  1  1 = A - B, 0 = A + B + carry_in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
carry_out  output  1  carry out of MSB (sub mode: 1 = no borrow, i.e. A >= B unsigned)
overflow  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: state = IDLE; out_valid, sum, carry_out, overflow and busy = 0. Counter, operand shift registers and carry register are cleared.
- in_ready = (state == IDLE) && !rst. It is combinational and is 1 in the first cycle after reset deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE, on in_valid && in_ready:
  - Capture A in shift register A.
  - Capture B ^ {WIDTH{sub}} in shift register B.
  - Load carry_reg = sub ? 1 : carry_in (carry_in is ignored when sub = 1).
  - Set bit counter to 0 and go to RUN.
- RUN, each cycle:
  - The full_adder takes A[0], B[0] and carry_reg.
  - Its sum bit shifts into the MSB of the result shift register, which shifts right.
  - The A and B shift registers shift right, and carry_reg takes the adder carry.
  - The counter increments.
  - When counter == WIDTH-1, the cycle processes the MSB and the state goes to DONE.
- Overflow: on the MSB cycle, overflow = carry_reg (carry into the MSB) XOR the adder carry out.
- Latency: the acceptance edge is E0. RUN occupies edges E1..E_WIDTH.
- On edge E_WIDTH:
  - sum, carry_out and overflow load together from the final values.
  - out_valid rises, so it first reads 1 exactly WIDTH cycles after E0.
- DONE:
  - out_valid = 1; sum, carry_out and overflow are held stable.
  - in_ready = 0; in_valid is ignored (no back-to-back overlap).
  - On out_valid && out_ready: out_valid clears on that edge and the state returns to IDLE.
  - The earliest next acceptance is one cycle later.
- After the handshake, sum, carry_out and overflow keep their last values until the next completion; they are meaningful only while out_valid = 1.
- Input operands and sub are sampled only at the acceptance edge. Changes during RUN have no effect.
- out_ready is don't-care outside DONE.
- Reset asserted in any state, including mid-RUN: the partial result is discarded and all outputs return to their reset values on that edge. No result is emitted for the aborted operation.
- Width rules:
  - The result wraps modulo 2^WIDTH.
  - The counter is clog2(WIDTH) bits wide and must reach WIDTH-1 without wrap.
- Subtraction is implemented as A + ~B + 1. carry_out = 1 means no borrow.

Test Plan (WIDTH=8):
- add 0x35+0x4A, carry_in=0 -> sum=0x7F, carry_out=0, overflow=0; out_valid first high exactly 8 cycles after the accept edge; busy high throughout.
- add 0xFF+0x01 -> 0x00, carry_out=1, overflow=0; add 0x7F+0x01 -> 0x80, carry_out=0, overflow=1; add 0xFF+0x00 with carry_in=1 -> 0x00, carry_out=1.
- sub 0x10-0x20 -> 0xF0, carry_out=0, overflow=0; sub 0x80-0x01 -> 0x7F, carry_out=1, overflow=1; sub with carry_in=1 gives the same result (carry_in ignored).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> outputs stable, in_ready=0, new operands not taken. Raise out_ready -> IDLE next cycle, then a new operation is accepted.
- Reset mid-operation: assert rst at the 3rd RUN cycle -> next cycle out_valid=0, busy=0, sum=0, in_ready=1. A following add 0x01+0x01 returns 0x02 with correct latency.
- Randomised: 1000 operations with random A, B, sub, carry_in and random out_ready stalls -> every result, carry_out and overflow matches the reference model; no result is lost or duplicated.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, one bit per clock,
// with valid/ready handshakes on operands and result.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q, overflow_q, out_valid_q;

  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] res_next;

  // The single full-adder cell.
  assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // res_q holds the WIDTH-1 bits already produced; the new bit enters at the top.
  assign res_next = {fa_sum, res_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= data_A;
            b_q     <= data_B ^ {WIDTH{sub}};
            carry_q <= sub | carry_in;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_next[WIDTH-1:1];
          carry_q <= fa_carry;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            sum_q       <= res_next;
            carry_out_q <= fa_carry;
            // Carry into the MSB differs from carry out of it: signed overflow.
            overflow_q  <= carry_q ^ fa_carry;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed literal cases plus randomised traffic checked every
// cycle against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_A, data_B;
  logic         carry_in, sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out, overflow, busy;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_A    (data_A),
    .data_B    (data_B),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract with sign rules.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic s,
                                 output logic [W-1:0] r, output logic co, output logic ov);
    int unsigned ua, ub, full;
    ua = 32'(a);
    ub = 32'(b);
    if (s) begin
      r  = W'(ua - ub);
      co = (ua >= ub);
      ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      full = ua + ub + 32'(cin);
      r    = W'(full);
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
  endfunction

  // Behavioural model: 0 idle, 1 computing (m_rem edges left), 2 result offered.
  int           m_phase = 0;
  int           m_rem = 0;
  bit           m_init = 1'b0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_co = 1'b0, m_ov = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_co, p_ov;
  logic [W-1:0] t_sum;
  logic         t_co, t_ov;
  int           m_acc = 0;
  int           m_del = 0;
  int           dut_del = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init  <= 1'b1;
      m_phase <= 0;
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_co    <= 1'b0;
      m_ov    <= 1'b0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        ref_op(data_A, data_B, carry_in, sub, t_sum, t_co, t_ov);
        p_sum   <= t_sum;
        p_co    <= t_co;
        p_ov    <= t_ov;
        m_rem   <= W;
        m_phase <= 1;
        m_acc   <= m_acc + 1;
      end
    end else if (m_phase == 1) begin
      if (m_rem == 1) begin
        m_sum   <= p_sum;
        m_co    <= p_co;
        m_ov    <= p_ov;
        m_valid <= 1'b1;
        m_phase <= 2;
      end else begin
        m_rem <= m_rem - 1;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_phase <= 0;
      m_del   <= m_del + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) dut_del <= dut_del + 1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk1("in_ready", in_ready, (m_phase == 0) && !rst);
      chk1("busy", busy, m_phase != 0);
      chk1("out_valid", out_valid, m_valid);
      chkw("sum", sum, m_sum);
      chk1("carry_out", carry_out, m_co);
      chk1("overflow", overflow, m_ov);
    end
  end

  // Called just after a rising edge with the block idle.
  task automatic op_lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic s, input logic [W-1:0] es,
                        input logic eco, input logic eov, input bit release_out);
    int lat;
    chk1({nm, "_in_ready"}, in_ready, 1'b1);
    data_A   = a;
    data_B   = b;
    carry_in = cin;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_A   = ~a;
    data_B   = ~b;
    sub      = ~s;
    chk1({nm, "_busy"}, busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    chki({nm, "_latency"}, lat, W);
    chkw({nm, "_sum"}, sum, es);
    chk1({nm, "_co"}, carry_out, eco);
    chk1({nm, "_ov"}, overflow, eov);
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk1({nm, "_released"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    int base;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_A = '0; data_B = '0; carry_in = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_sum", sum, 8'h00);

    op_lit("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    op_lit("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    op_lit("add7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    op_lit("addff_00c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    op_lit("sub10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
    op_lit("sub80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
    op_lit("sub80_01c", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);

    // Backpressure: result held while new operands are offered and refused.
    op_lit("bp", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      data_A   = 8'(i * 17);
      data_B   = 8'(i * 5 + 3);
      @(posedge clk); #1;
      chk1("bp_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chkw("bp_sum", sum, 8'h46);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1("bp_idle", in_ready, 1'b1);
    chk1("bp_drop", out_valid, 1'b0);
    op_lit("bp_next", 8'h20, 8'h22, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);

    // Reset during the third RUN cycle.
    data_A = 8'h55; data_B = 8'h22; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk1("mrst_valid", out_valid, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chkw("mrst_sum", sum, 8'h00);
    rst = 1'b0;
    #1;
    chk1("mrst_in_ready", in_ready, 1'b1);
    op_lit("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);

    // Randomised traffic with random consumer stalls.
    base = m_acc;
    cyc  = 0;
    while (m_acc < base + 1000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      data_A    = W'($urandom);
      data_B    = W'($urandom);
      carry_in  = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    chk1("rand_complete", m_acc >= base + 1000, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (m_phase != 0 && cyc < 4 * W) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk1("drain", m_phase == 0, 1'b1);
    chki("deliveries", dut_del, m_del);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
